// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux8_scan_ctrl scan sequencer.
// Optional frame parity output is enabled by defining MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int SEL_W_DEF  = 3;
  localparam int DWELL_DEF  = 4;

  // Width needed to hold 0..dwell; never below one bit.
  function automatic int cnt_width(input int dwell);
    return (dwell < 1) ? 1 : $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled and pulses tick on the last count.
// The tick is combinational so the owner samples on the same edge the counter wraps.
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter  int DWELL = DWELL_DEF,
  localparam int CW    = cnt_width(DWELL)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DWELL - 1));

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; reset is synchronous and sits inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for the 8:1 bit mux: steps sel, samples each channel after DWELL
// cycles and hands out the assembled frame with valid/ready. Macro: MUX_SCAN_PARITY_EN.
module mux8_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int DWELL  = DWELL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [NUM_CH-1:0] frame,
  output logic              frame_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic              frame_parity,
`endif
  input  logic              frame_ready
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_e       state, state_next;
  logic [SEL_W-1:0]  sel_next;
  logic [NUM_CH-1:0] asm_q, asm_next;
  logic [NUM_CH-1:0] frame_next;
  logic              valid_next;
  logic              cnt_en;
  logic              tick;

  // The counter only runs in SCAN; any other state (or an abort) holds it at zero,
  // so every scan entry starts a fresh dwell window.
  assign cnt_en = (state == SCAN) && !abort;

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!cnt_en),
    .en    (cnt_en),
    .tick  (tick)
  );

  assign busy = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path
  // through the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sel_next   = sel;
    asm_next   = asm_q;
    frame_next = frame;
    valid_next = frame_valid;

    if (abort) begin
      state_next = IDLE;
      sel_next   = '0;
      asm_next   = '0;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_next = SCAN;
            sel_next   = '0;
            asm_next   = '0;
          end
        end
        SCAN: begin
          if (tick) begin
            asm_next[sel] = mux_out;
            if (sel == LAST_SEL) begin
              frame_next = asm_next;
              valid_next = 1'b1;
              state_next = HOLD;
              asm_next   = '0;
            end else begin
              sel_next = sel + SEL_W'(1);
            end
          end
        end
        HOLD: begin
          if (frame_valid && frame_ready) begin
            valid_next = 1'b0;
            sel_next   = '0;
            state_next = cont ? SCAN : IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      asm_q       <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_next;
      sel         <= sel_next;
      asm_q       <= asm_next;
      frame       <= frame_next;
      frame_valid <= valid_next;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  // Tracks frame exactly: it changes only on the edge frame is loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_parity <= 1'b0;
    end else begin
      frame_parity <= ^frame_next;
    end
  end
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: default build plus a DWELL=1 instance.
// Parity checks are compiled in when MUX_SCAN_PARITY_EN is defined.
module tb_mux8_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic       frame_ready = 1'b1;
  logic [7:0] pattern = 8'h00;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] frame;
  logic       frame_valid;

  logic       start1 = 1'b0;
  logic [7:0] pattern1 = 8'hFF;
  logic       mux_out1;
  logic [2:0] sel1;
  logic       busy1;
  logic [7:0] frame1;
  logic       frame_valid1;

`ifdef MUX_SCAN_PARITY_EN
  logic       frame_parity;
  logic       frame_parity1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Mux model: returns bit sel of the current pattern.
  assign mux_out  = pattern[sel];
  assign mux_out1 = pattern1[sel1];

  mux8_scan_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cont         (cont),
    .abort        (abort),
    .mux_out      (mux_out),
    .sel          (sel),
    .busy         (busy),
    .frame        (frame),
    .frame_valid  (frame_valid),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity (frame_parity),
`endif
    .frame_ready  (frame_ready)
  );

  mux8_scan_ctrl #(.DWELL(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start1),
    .cont         (1'b0),
    .abort        (1'b0),
    .mux_out      (mux_out1),
    .sel          (sel1),
    .busy         (busy1),
    .frame        (frame1),
    .frame_valid  (frame_valid1),
`ifdef MUX_SCAN_PARITY_EN
    .frame_parity (frame_parity1),
`endif
    .frame_ready  (1'b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge right after the accepting edge (k = 0).
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    step(2);
    check("rst_sel",   32'(sel), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_frame", 32'(frame), 32'h00);
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_valid1", 32'(frame_valid1), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Basic frame: sel walks 0..7 with four cycles per channel.
    pattern = 8'hA5;
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("basic_sel_k%0d", k), 32'(sel), 32'(k / 4));
      if (k == 31) check("basic_valid_early", 32'(frame_valid), 32'd0);
      step(1);
    end
    check("basic_valid", 32'(frame_valid), 32'd1);
    check("basic_frame", 32'(frame), 32'hA5);
    check("basic_busy",  32'(busy), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
    check("parity_a5", 32'(frame_parity), 32'd0);
`endif
    step(1);
    check("basic_valid_drop", 32'(frame_valid), 32'd0);
    check("basic_idle_busy",  32'(busy), 32'd0);
    check("basic_idle_sel",   32'(sel), 32'd0);
    check("basic_frame_kept", 32'(frame), 32'hA5);

    // Backpressure: frame held for ten cycles, released one edge after ready.
    frame_ready = 1'b0;
    pulse_start();
    step(32);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), 32'(frame_valid), 32'd1);
      check($sformatf("bp_frame_%0d", i), 32'(frame), 32'hA5);
      step(1);
    end
    frame_ready = 1'b1;
    step(1);
    check("bp_valid_drop", 32'(frame_valid), 32'd0);
    check("bp_busy", 32'(busy), 32'd0);

    // Continuous: frames 3C then C3, valid edges 33 cycles apart.
    cont = 1'b1;
    pattern = 8'h3C;
    pulse_start();
    step(32);
    check("cont_valid0", 32'(frame_valid), 32'd1);
    check("cont_frame0", 32'(frame), 32'h3C);
    pattern = 8'hC3;
    step(1);
    check("cont_restart_valid", 32'(frame_valid), 32'd0);
    check("cont_restart_busy",  32'(busy), 32'd1);
    check("cont_restart_sel",   32'(sel), 32'd0);
    step(31);
    check("cont_valid1_early", 32'(frame_valid), 32'd0);
    step(1);
    check("cont_valid1", 32'(frame_valid), 32'd1);
    check("cont_frame1", 32'(frame), 32'hC3);
    cont = 1'b0;
    step(1);
    check("cont_end_busy", 32'(busy), 32'd0);

    // Abort at sel=5 together with start: abort wins, frame untouched.
    pattern = 8'h5A;
    pulse_start();
    step(21);
    check("abort_pre_sel", 32'(sel), 32'd5);
    abort = 1'b1;
    start = 1'b1;
    step(1);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_sel",   32'(sel), 32'd0);
    check("abort_valid", 32'(frame_valid), 32'd0);
    check("abort_frame", 32'(frame), 32'hC3);
    step(1);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // Reset mid-scan at sel=3.
    pulse_start();
    step(12);
    check("rst_pre_sel", 32'(sel), 32'd3);
    rst_n = 1'b0;
    step(1);
    check("midrst_sel",   32'(sel), 32'd0);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_frame", 32'(frame), 32'h00);
    check("midrst_valid", 32'(frame_valid), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("midrst_parity", 32'(frame_parity), 32'd0);
`endif
    rst_n = 1'b1;
    step(1);

    // Odd-weight frame.
    pattern = 8'hA4;
    pulse_start();
    step(32);
    check("a4_valid", 32'(frame_valid), 32'd1);
    check("a4_frame", 32'(frame), 32'hA4);
`ifdef MUX_SCAN_PARITY_EN
    check("parity_a4", 32'(frame_parity), 32'd1);
`endif
    step(1);

    // DWELL=1 instance: one sample per cycle, frame after 8 edges.
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    step(7);
    check("d1_valid_early", 32'(frame_valid1), 32'd0);
    check("d1_sel_k7", 32'(sel1), 32'd7);
    step(1);
    check("d1_valid", 32'(frame_valid1), 32'd1);
    check("d1_frame", 32'(frame1), 32'hFF);
    step(1);
    check("d1_valid_drop", 32'(frame_valid1), 32'd0);
    check("d1_busy", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
